// File: rtl/scale_scheduler.sv
// Scaler copy scheduler: waits for a stable mode, launches one framebuffer copy per
// vertical blank, tracks completion/timeout and publishes the centred image geometry.
module scale_scheduler #(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int SCR_W       = 640,
    parameter int SCR_H       = 480,
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] mode,
    input  logic       frame_start,
    input  logic       copy_done,
    output logic       copy_start,
    output logic [3:0] copy_mode,
    output logic [9:0] img_w,
    output logic [9:0] img_h,
    output logic [9:0] x_off,
    output logic [9:0] y_off,
    output logic       disp_enable,
    output logic       busy,
    output logic       err_timeout
);
    localparam int SW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SW-1:0] STABLE_LAST  = SW'(STABLE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [31:0]   RST_X = (32'(SCR_W) - 32'(IMG_W)) >> 1;
    localparam logic [31:0]   RST_Y = (32'(SCR_H) - 32'(IMG_H)) >> 1;

    typedef enum logic [2:0] {IDLE, SETTLE, WAIT_VBL, COPY, SHOW, FAULT} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    mode_prev_reg;
    logic [SW-1:0] stable_cnt_reg, stable_cnt_next;
    logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic          pending_reg, pending_next;
    logic          copy_start_reg, launch;
    logic          set_err;
    logic [3:0]    copy_mode_reg;
    logic [9:0]    img_w_reg, img_h_reg, x_off_reg, y_off_reg;
    logic          disp_enable_reg, busy_reg, err_timeout_reg;
    logic [31:0]   geo_w, geo_h, geo_x, geo_y;
    logic          mode_changed, mode_differs;

    assign mode_changed = (mode != mode_prev_reg);
    assign mode_differs = (mode != copy_mode_reg);

    // Geometry is evaluated in 32 bits and only truncated when latched.
    always_comb begin
        if (mode[2]) begin
            geo_w = 32'(IMG_W);
            geo_h = 32'(IMG_H);
        end else if (!mode[0]) begin
            geo_w = mode[3] ? 32'(IMG_W * 4) : 32'(IMG_W * 2);
            geo_h = mode[3] ? 32'(IMG_H * 4) : 32'(IMG_H * 2);
        end else begin
            geo_w = mode[3] ? 32'(IMG_W / 4) : 32'(IMG_W / 2);
            geo_h = mode[3] ? 32'(IMG_H / 4) : 32'(IMG_H / 2);
        end
        geo_x = (32'(SCR_W) - geo_w) >> 1;
        geo_y = (32'(SCR_H) - geo_h) >> 1;
    end

    always_comb begin
        state_next      = state_reg;
        stable_cnt_next = '0;
        tmo_cnt_next    = '0;
        pending_next    = 1'b0;
        launch          = 1'b0;
        set_err         = 1'b0;
        case (state_reg)
            IDLE: state_next = SETTLE;
            SETTLE: begin
                if (mode_changed)
                    stable_cnt_next = '0;
                else if (stable_cnt_reg == STABLE_LAST)
                    state_next = WAIT_VBL;
                else
                    stable_cnt_next = stable_cnt_reg + 1'b1;
            end
            WAIT_VBL: begin
                if (mode_changed) begin
                    state_next = SETTLE;
                end else if (frame_start) begin
                    launch     = 1'b1;
                    state_next = COPY;
                end
            end
            COPY: begin
                // copy_done seen while copy_start is still high belongs to the previous copy
                pending_next = pending_reg | mode_differs;
                if (copy_done && !copy_start_reg) begin
                    state_next   = pending_next ? SETTLE : SHOW;
                    pending_next = 1'b0;
                end else if (tmo_cnt_reg == TIMEOUT_LAST) begin
                    state_next   = FAULT;
                    set_err      = 1'b1;
                    pending_next = 1'b0;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            SHOW, FAULT: if (mode_differs) state_next = SETTLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            mode_prev_reg   <= '0;
            stable_cnt_reg  <= '0;
            tmo_cnt_reg     <= '0;
            pending_reg     <= 1'b0;
            copy_start_reg  <= 1'b0;
            copy_mode_reg   <= '0;
            img_w_reg       <= 10'(IMG_W);
            img_h_reg       <= 10'(IMG_H);
            x_off_reg       <= RST_X[9:0];
            y_off_reg       <= RST_Y[9:0];
            disp_enable_reg <= 1'b0;
            busy_reg        <= 1'b1;
            err_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            mode_prev_reg   <= mode;
            stable_cnt_reg  <= stable_cnt_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            pending_reg     <= pending_next;
            copy_start_reg  <= launch;
            if (launch) begin
                copy_mode_reg <= mode;
                img_w_reg     <= geo_w[9:0];
                img_h_reg     <= geo_h[9:0];
                x_off_reg     <= geo_x[9:0];
                y_off_reg     <= geo_y[9:0];
            end
            disp_enable_reg <= (state_next == SHOW);
            busy_reg        <= !((state_next == SHOW) || (state_next == FAULT));
            err_timeout_reg <= err_timeout_reg | set_err;
        end
    end

    assign copy_start  = copy_start_reg;
    assign copy_mode   = copy_mode_reg;
    assign img_w       = img_w_reg;
    assign img_h       = img_h_reg;
    assign x_off       = x_off_reg;
    assign y_off       = y_off_reg;
    assign disp_enable = disp_enable_reg;
    assign busy        = busy_reg;
    assign err_timeout = err_timeout_reg;
endmodule

// File: tb/tb_scale_scheduler.sv
// Directed bench for scale_scheduler; launches are scoreboarded, one line per copy_start.
module tb_scale_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] mode = 4'b0000;
    logic       frame_start = 1'b0;
    logic       copy_done = 1'b0;

    logic       copy_start, disp_enable, busy, err_timeout;
    logic [3:0] copy_mode;
    logic [9:0] img_w, img_h, x_off, y_off;

    logic       cs_to, de_to, busy_to, err_to;
    logic [3:0] cm_to;
    logic [9:0] w_to, h_to, x_to, y_to;

    int n_vec = 0;
    int n_err = 0;
    int starts_seen = 0;

    typedef struct packed {
        logic [3:0] m;
        logic [9:0] w, h, x, y;
    } exp_t;
    exp_t exp_q[$];

    scale_scheduler dut (
        .clk(clk), .reset(reset), .mode(mode), .frame_start(frame_start),
        .copy_done(copy_done), .copy_start(copy_start), .copy_mode(copy_mode),
        .img_w(img_w), .img_h(img_h), .x_off(x_off), .y_off(y_off),
        .disp_enable(disp_enable), .busy(busy), .err_timeout(err_timeout)
    );

    scale_scheduler #(.TIMEOUT_CYC(64)) dut_to (
        .clk(clk), .reset(reset), .mode(mode), .frame_start(frame_start),
        .copy_done(copy_done), .copy_start(cs_to), .copy_mode(cm_to),
        .img_w(w_to), .img_h(h_to), .x_off(x_to), .y_off(y_to),
        .disp_enable(de_to), .busy(busy_to), .err_timeout(err_to)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch(input logic [3:0] m, input int w, input int h, input int x, input int y);
        exp_t e;
        e.m = m; e.w = 10'(w); e.h = 10'(h); e.x = 10'(x); e.y = 10'(y);
        exp_q.push_back(e);
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
    endtask

    task automatic pulse_done();
        copy_done = 1'b1;
        cyc(1);
        copy_done = 1'b0;
    endtask

    // Scoreboard: every copy_start must match the oldest pending expectation
    always @(negedge clk) begin
        if (copy_start === 1'b1) begin
            exp_t e;
            starts_seen++;
            check("copy_start_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("copy_start %0d: mode=%b w=%0d h=%0d x=%0d y=%0d", starts_seen,
                         copy_mode, img_w, img_h, x_off, y_off);
                check("copy_mode", 32'(copy_mode), 32'(e.m));
                check("img_w", 32'(img_w), 32'(e.w));
                check("img_h", 32'(img_h), 32'(e.h));
                check("x_off", 32'(x_off), 32'(e.x));
                check("y_off", 32'(y_off), 32'(e.y));
            end
        end
    end

    initial begin
        int s0;
        reset = 1'b1;
        #2 reset = 1'b0;
        cyc(3);
        check("rst_copy_start", 32'(copy_start), 0);
        check("rst_copy_mode", 32'(copy_mode), 0);
        check("rst_img_w", 32'(img_w), 160);
        check("rst_img_h", 32'(img_h), 120);
        check("rst_x_off", 32'(x_off), 240);
        check("rst_y_off", 32'(y_off), 180);
        check("rst_disp", 32'(disp_enable), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_err", 32'(err_timeout), 0);
        reset = 1'b1;

        // power-up copy, completion 100 cycles after frame_start
        cyc(20);
        launch(4'b0000, 320, 240, 160, 120);
        check("s1_busy_copy", 32'(busy), 1);
        check("s1_disp_copy", 32'(disp_enable), 0);
        cyc(98);
        pulse_done();
        check("s1_disp_show", 32'(disp_enable), 1);
        check("s1_busy_show", 32'(busy), 0);
        check("s1_img_w", 32'(img_w), 320);

        // decimate by 4
        mode = 4'b1001;
        cyc(1);
        check("s2_disp_drop", 32'(disp_enable), 0);
        check("s2_geo_held", 32'(img_w), 320);
        cyc(20);
        launch(4'b1001, 40, 30, 300, 225);
        cyc(10);
        pulse_done();
        check("s2_disp_show", 32'(disp_enable), 1);

        // unstable mode must never launch
        s0 = starts_seen;
        for (int i = 0; i < 13; i++) begin
            mode = i[0] ? 4'b0101 : 4'b0000;
            cyc(4);
            frame_start = 1'b1;
            cyc(1);
            frame_start = 1'b0;
            cyc(3);
        end
        mode = 4'b1000;
        cyc(10);
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
        check("s3_no_start", 32'(starts_seen), 32'(s0));
        check("s3_busy", 32'(busy), 1);
        check("s3_geo_held", 32'(img_w), 40);
        cyc(10);
        launch(4'b1000, 640, 480, 0, 0);
        cyc(5);
        pulse_done();
        check("s3_disp_show", 32'(disp_enable), 1);

        // mode change during COPY forces a re-copy
        mode = 4'b0001;
        cyc(20);
        launch(4'b0001, 80, 60, 280, 210);
        cyc(5);
        mode = 4'b0100;
        cyc(5);
        pulse_done();
        check("s4_disp_after_done", 32'(disp_enable), 0);
        check("s4_busy_after_done", 32'(busy), 1);
        cyc(10);
        check("s4_disp_settle", 32'(disp_enable), 0);
        check("s4_geo_held", 32'(img_w), 80);
        cyc(10);
        launch(4'b0100, 160, 120, 240, 180);
        cyc(3);
        pulse_done();
        check("s4_disp_show", 32'(disp_enable), 1);

        // stale copy_done at launch is not a completion
        mode = 4'b0000;
        cyc(20);
        copy_done = 1'b1;
        launch(4'b0000, 320, 240, 160, 120);
        cyc(1);
        copy_done = 1'b0;
        check("s5_stale_disp", 32'(disp_enable), 0);
        check("s5_stale_busy", 32'(busy), 1);
        cyc(5);
        check("s5_still_copy", 32'(busy), 1);
        pulse_done();
        check("s5_disp_show", 32'(disp_enable), 1);

        // reset mid-COPY abandons the copy
        mode = 4'b1100;
        cyc(20);
        launch(4'b1100, 160, 120, 240, 180);
        cyc(3);
        reset = 1'b0;
        #1;
        check("s6_async_copy_mode", 32'(copy_mode), 0);
        check("s6_async_busy", 32'(busy), 1);
        check("s6_async_img_w", 32'(img_w), 160);
        cyc(2);
        reset = 1'b1;
        pulse_done();
        cyc(1);
        check("s6_done_ignored", 32'(disp_enable), 0);
        check("s6_busy", 32'(busy), 1);

        // timeout on the TIMEOUT_CYC=64 instance
        cyc(20);
        launch(4'b1100, 160, 120, 240, 180);
        check("s7_to_copy_mode", 32'(cm_to), 32'(4'b1100));
        cyc(63);
        check("s7_err_before", 32'(err_to), 0);
        check("s7_busy_before", 32'(busy_to), 1);
        cyc(1);
        check("s7_err_set", 32'(err_to), 1);
        check("s7_fault_busy", 32'(busy_to), 0);
        check("s7_fault_disp", 32'(de_to), 0);
        check("s7_main_no_err", 32'(err_timeout), 0);
        mode = 4'b0000;
        cyc(1);
        check("s7_settle_busy", 32'(busy_to), 1);
        check("s7_err_sticky", 32'(err_to), 1);
        cyc(5);
        check("s7_err_sticky2", 32'(err_to), 1);

        check("all_copies_seen", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
